// File: rtl/core_test_monitor.sv
// Writeback snooper that shadows the register file, detects end-of-test or timeout,
// then walks a masked expected-value table and reports pass/fail results.
module core_test_monitor #(
    parameter int XLEN           = 32,
    parameter int NUM_REGS       = 32,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int END_REG        = 31,
    parameter int CNT_W          = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        exp_we,
    input  logic                        exp_clr,
    input  logic [$clog2(NUM_REGS)-1:0] exp_addr,
    input  logic [XLEN-1:0]             exp_data,
    input  logic                        wb_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]             wb_rd_data,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
    output logic [XLEN-1:0]             dbg_data,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        timed_out,
    output logic [$clog2(NUM_REGS):0]   fail_count,
    output logic [$clog2(NUM_REGS)-1:0] first_fail_addr,
    output logic [CNT_W-1:0]            cycle_count,
    output logic [CNT_W-1:0]            retired_count
);

    localparam int               AW           = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0]    END_ADDR     = AW'(END_REG);
    localparam logic [AW-1:0]    LAST_IDX     = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0]    FIRST_IDX    = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CHECK,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [XLEN-1:0]   shadow   [NUM_REGS];
    logic [XLEN-1:0]   expected [NUM_REGS];
    logic [NUM_REGS-1:0] mask;
    logic [AW-1:0]     check_idx;

    logic              idle_or_done;
    logic              end_marker;
    logic              timeout_hit;
    logic              mismatch;

    assign idle_or_done = (state == IDLE) || (state == DONE);
    assign end_marker   = wb_wr_en && (wb_rd_addr == END_ADDR) && (wb_rd_data != '0);
    // The end marker outranks a timeout landing in the same cycle.
    assign timeout_hit  = (cycle_count == TIMEOUT_LAST) && !end_marker;
    assign mismatch     = mask[check_idx] && (shadow[check_idx] != expected[check_idx]);

    assign dbg_data = shadow[dbg_addr];
    assign busy     = (state == RUN) || (state == CHECK);
    assign done     = (state == DONE);
    assign pass     = done && (fail_count == '0) && !timed_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (end_marker || timeout_hit) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (check_idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Expected-table programming, shadow capture, counters and the check walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i]   <= '0;
                expected[i] <= '0;
            end
            mask            <= '0;
            check_idx       <= FIRST_IDX;
            timed_out       <= 1'b0;
            fail_count      <= '0;
            first_fail_addr <= '0;
            cycle_count     <= '0;
            retired_count   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (exp_clr) begin
                        mask <= '0;
                    end else if (exp_we && (exp_addr != '0)) begin
                        expected[exp_addr] <= exp_data;
                        mask[exp_addr]     <= 1'b1;
                    end
                    if (start) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            shadow[i] <= '0;
                        end
                        check_idx       <= FIRST_IDX;
                        timed_out       <= 1'b0;
                        fail_count      <= '0;
                        first_fail_addr <= '0;
                        cycle_count     <= '0;
                        retired_count   <= '0;
                    end
                end
                RUN: begin
                    cycle_count <= cycle_count + 1'b1;
                    if (wb_wr_en) begin
                        retired_count <= retired_count + 1'b1;
                        if (wb_rd_addr != '0) begin
                            shadow[wb_rd_addr] <= wb_rd_data;
                        end
                    end
                    if (end_marker) begin
                        timed_out <= 1'b0;
                        check_idx <= FIRST_IDX;
                    end else if (timeout_hit) begin
                        timed_out <= 1'b1;
                        check_idx <= FIRST_IDX;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_count <= fail_count + 1'b1;
                        if (fail_count == '0) begin
                            first_fail_addr <= check_idx;
                        end
                    end
                    check_idx <= check_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_test_monitor.sv
// Self-checking bench for core_test_monitor: table vectors, directed corner sequences
// and randomized runs compared against a run-level reference model.
module tb_core_test_monitor;

    localparam int TIMEOUT = 100;
    localparam int NREGS   = 32;
    localparam int PMAX    = 256;

    logic        clk;
    logic        rst;
    logic        start;
    logic        exp_we;
    logic        exp_clr;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        wb_wr_en;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timed_out;
    logic [5:0]  fail_count;
    logic [4:0]  first_fail_addr;
    logic [31:0] cycle_count;
    logic [31:0] retired_count;

    core_test_monitor #(
        .XLEN(32),
        .NUM_REGS(NREGS),
        .TIMEOUT_CYCLES(TIMEOUT),
        .END_REG(31),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .exp_we(exp_we),
        .exp_clr(exp_clr),
        .exp_addr(exp_addr),
        .exp_data(exp_data),
        .wb_wr_en(wb_wr_en),
        .wb_rd_addr(wb_rd_addr),
        .wb_rd_data(wb_rd_data),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .busy(busy),
        .done(done),
        .pass(pass),
        .timed_out(timed_out),
        .fail_count(fail_count),
        .first_fail_addr(first_fail_addr),
        .cycle_count(cycle_count),
        .retired_count(retired_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state: architectural view of expected table, mask and shadow.
    logic [31:0] m_shadow [NREGS];
    logic [31:0] m_exp    [NREGS];
    bit          m_mask   [NREGS];

    // Per-cycle RUN program.
    bit          prog_en    [PMAX];
    logic [4:0]  prog_addr  [PMAX];
    logic [31:0] prog_data  [PMAX];
    bit          prog_start [PMAX];
    bit          prog_expwe [PMAX];
    int          prog_len;
    int          last_ticks;

    typedef struct {
        bit          both;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [4:0]  w_addr;
        logic [31:0] w_data;
        int          x_fail;
        int          x_first;
        bit          x_pass;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        start      = 1'b0;
        exp_we     = 1'b0;
        exp_clr    = 1'b0;
        exp_addr   = '0;
        exp_data   = '0;
        wb_wr_en   = 1'b0;
        wb_rd_addr = '0;
        wb_rd_data = '0;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREGS; i++) begin
            m_shadow[i] = '0;
            m_exp[i]    = '0;
            m_mask[i]   = 1'b0;
        end
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        modelReset();
    endtask

    task automatic progExp(input logic [4:0] addr, input logic [31:0] data);
        exp_we   = 1'b1;
        exp_addr = addr;
        exp_data = data;
        tick();
        idleInputs();
        if (addr != 0) begin
            m_exp[addr]  = data;
            m_mask[addr] = 1'b1;
        end
    endtask

    task automatic clrMask();
        exp_clr = 1'b1;
        tick();
        idleInputs();
        for (int i = 0; i < NREGS; i++) m_mask[i] = 1'b0;
    endtask

    task automatic clearProg();
        for (int k = 0; k < PMAX; k++) begin
            prog_en[k]    = 1'b0;
            prog_addr[k]  = '0;
            prog_data[k]  = '0;
            prog_start[k] = 1'b0;
            prog_expwe[k] = 1'b0;
        end
        prog_len = 0;
    endtask

    task automatic addWb(input logic [4:0] addr, input logic [31:0] data);
        prog_en[prog_len]   = 1'b1;
        prog_addr[prog_len] = addr;
        prog_data[prog_len] = data;
        prog_len++;
    endtask

    task automatic addIdle(input int n);
        prog_len += n;
    endtask

    task automatic applyStimulus(input int k);
        if (k < prog_len && k < PMAX) begin
            wb_wr_en   = prog_en[k];
            wb_rd_addr = prog_addr[k];
            wb_rd_data = prog_data[k];
            start      = prog_start[k];
            exp_we     = prog_expwe[k];
            exp_addr   = prog_addr[k];
            exp_data   = prog_data[k] + 32'd1;
        end else begin
            idleInputs();
        end
    endtask

    // Starts a run, plays the program, waits for done and compares against the model.
    task automatic executeRun(input string tag);
        int run_len;
        bit tmo;
        int ret;
        int fails;
        int ffirst;
        int ticks;
        bit pass_early;
        bit x_pass;

        start = 1'b1;
        tick();
        start = 1'b0;

        for (int i = 0; i < NREGS; i++) m_shadow[i] = '0;
        run_len = TIMEOUT;
        tmo     = 1'b1;
        for (int k = 0; k < TIMEOUT; k++) begin
            if (k < prog_len && prog_en[k] && prog_addr[k] == 5'd31 && prog_data[k] != 0) begin
                run_len = k + 1;
                tmo     = 1'b0;
                break;
            end
        end
        ret = 0;
        for (int k = 0; k < run_len && k < prog_len; k++) begin
            if (prog_en[k]) begin
                ret++;
                if (prog_addr[k] != 0) m_shadow[prog_addr[k]] = prog_data[k];
            end
        end
        fails  = 0;
        ffirst = 0;
        for (int i = 1; i < NREGS; i++) begin
            if (m_mask[i] && m_shadow[i] != m_exp[i]) begin
                if (fails == 0) ffirst = i;
                fails++;
            end
        end
        x_pass = (fails == 0) && !tmo;

        ticks      = 0;
        pass_early = 1'b0;
        while (ticks < 300) begin
            applyStimulus(ticks);
            tick();
            ticks++;
            if (done) break;
            if (pass) pass_early = 1'b1;
        end
        idleInputs();
        last_ticks = ticks;

        checkOutput({tag, ".done_latency"}, 64'(ticks), 64'(run_len + NREGS - 1));
        checkOutput({tag, ".done"}, 64'(done), 64'd1);
        checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
        checkOutput({tag, ".pass_before_done"}, 64'(pass_early), 64'd0);
        checkOutput({tag, ".pass"}, 64'(pass), 64'(x_pass));
        checkOutput({tag, ".timed_out"}, 64'(timed_out), 64'(tmo));
        checkOutput({tag, ".fail_count"}, 64'(fail_count), 64'(fails));
        checkOutput({tag, ".first_fail"}, 64'(first_fail_addr), 64'(ffirst));
        checkOutput({tag, ".cycle_count"}, 64'(cycle_count), 64'(run_len));
        checkOutput({tag, ".retired"}, 64'(retired_count), 64'(ret));
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = 5'(i);
            #1;
            checkOutput($sformatf("%s.shadow[%0d]", tag, i), 64'(dbg_data), 64'(m_shadow[i]));
        end
        dbg_addr = '0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        dbg_addr = '0;
        rst      = 1'b1;
        idleInputs();
        vecs[0] = '{1'b0, 5'd3,  32'd10,         5'd3,  32'd10,         0, 0,  1'b1};
        vecs[1] = '{1'b0, 5'd3,  32'd10,         5'd3,  32'd11,         1, 3,  1'b0};
        vecs[2] = '{1'b0, 5'd0,  32'd5,          5'd4,  32'd5,          0, 0,  1'b1};
        vecs[3] = '{1'b0, 5'd30, 32'hFFFF_FFFF,  5'd30, 32'hFFFF_FFFF,  0, 0,  1'b1};
        vecs[4] = '{1'b0, 5'd31, 32'd2,          5'd5,  32'd1,          1, 31, 1'b0};
        vecs[5] = '{1'b0, 5'd1,  32'd1,          5'd2,  32'd7,          1, 1,  1'b0};
        vecs[6] = '{1'b1, 5'd6,  32'd9,          5'd6,  32'd8,          0, 0,  1'b1};
        vecs[7] = '{1'b0, 5'd31, 32'd1,          5'd0,  32'd9,          0, 0,  1'b1};

        doReset();
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.pass", 64'(pass), 64'd0);
        checkOutput("reset.fail_count", 64'(fail_count), 64'd0);
        checkOutput("reset.cycle_count", 64'(cycle_count), 64'd0);
        checkOutput("reset.retired", 64'(retired_count), 64'd0);

        // Table-driven single-register scenarios.
        for (int v = 0; v < 8; v++) begin
            clrMask();
            if (vecs[v].both) begin
                exp_clr  = 1'b1;
                exp_we   = 1'b1;
                exp_addr = vecs[v].e_addr;
                exp_data = vecs[v].e_data;
                tick();
                idleInputs();
                for (int i = 0; i < NREGS; i++) m_mask[i] = 1'b0;
            end else begin
                progExp(vecs[v].e_addr, vecs[v].e_data);
            end
            clearProg();
            addWb(vecs[v].w_addr, vecs[v].w_data);
            addWb(5'd31, 32'd1);
            executeRun($sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d.tbl_fail", v), 64'(fail_count), 64'(vecs[v].x_fail));
            checkOutput($sformatf("vec%0d.tbl_first", v), 64'(first_fail_addr), 64'(vecs[v].x_first));
            checkOutput($sformatf("vec%0d.tbl_pass", v), 64'(pass), 64'(vecs[v].x_pass));
        end

        // Sum run with interleaved writebacks.
        clrMask();
        progExp(5'd1, 32'd0);
        progExp(5'd2, 32'd15);
        clearProg();
        addWb(5'd1, 32'd5);  addWb(5'd2, 32'd5);
        addWb(5'd1, 32'd4);  addWb(5'd2, 32'd9);
        addWb(5'd1, 32'd3);  addWb(5'd2, 32'd12);
        addWb(5'd1, 32'd2);  addWb(5'd2, 32'd14);
        addWb(5'd1, 32'd1);  addWb(5'd2, 32'd15);
        addWb(5'd1, 32'd0);  addWb(5'd31, 32'd1);
        executeRun("sum");
        checkOutput("sum.pass", 64'(pass), 64'd1);
        checkOutput("sum.retired", 64'(retired_count), 64'd12);
        checkOutput("sum.latency", 64'(last_ticks), 64'd43);

        // Two of three masked registers mismatch.
        clrMask();
        progExp(5'd5, 32'd1);
        progExp(5'd7, 32'd1);
        progExp(5'd9, 32'd1);
        clearProg();
        addWb(5'd5, 32'd2);
        addWb(5'd7, 32'd1);
        addWb(5'd9, 32'd0);
        addWb(5'd31, 32'd1);
        executeRun("mismatch");
        checkOutput("mismatch.fail_count", 64'(fail_count), 64'd2);
        checkOutput("mismatch.first_fail", 64'(first_fail_addr), 64'd5);
        checkOutput("mismatch.pass", 64'(pass), 64'd0);
        checkOutput("mismatch.timed_out", 64'(timed_out), 64'd0);

        // Timeout with a matching register.
        clrMask();
        progExp(5'd2, 32'd15);
        clearProg();
        addIdle(3);
        addWb(5'd2, 32'd15);
        executeRun("timeout");
        checkOutput("timeout.cycle_count", 64'(cycle_count), 64'd100);
        checkOutput("timeout.timed_out", 64'(timed_out), 64'd1);
        checkOutput("timeout.fail_count", 64'(fail_count), 64'd0);
        checkOutput("timeout.pass", 64'(pass), 64'd0);

        // x0 rules and start ignored in RUN.
        clrMask();
        progExp(5'd0, 32'd7);
        clearProg();
        addWb(5'd0, 32'd7);
        prog_start[1] = 1'b1;
        addIdle(1);
        addWb(5'd1, 32'd3);
        addIdle(2);
        addWb(5'd31, 32'd1);
        executeRun("x0");
        checkOutput("x0.retired", 64'(retired_count), 64'd3);
        checkOutput("x0.cycle_count", 64'(cycle_count), 64'd6);
        checkOutput("x0.pass", 64'(pass), 64'd1);

        // End marker on the final allowed RUN cycle beats the timeout.
        clrMask();
        clearProg();
        addIdle(TIMEOUT - 1);
        addWb(5'd31, 32'd1);
        executeRun("collision");
        checkOutput("collision.timed_out", 64'(timed_out), 64'd0);
        checkOutput("collision.pass", 64'(pass), 64'd1);

        // Reset in the middle of a run, then restart with an empty table.
        progExp(5'd2, 32'd15);
        clearProg();
        addWb(5'd3, 32'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(k);
            tick();
        end
        idleInputs();
        checkOutput("midrst.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelReset();
        dbg_addr = 5'd3;
        #1;
        checkOutput("midrst.busy", 64'(busy), 64'd0);
        checkOutput("midrst.done", 64'(done), 64'd0);
        checkOutput("midrst.pass", 64'(pass), 64'd0);
        checkOutput("midrst.timed_out", 64'(timed_out), 64'd0);
        checkOutput("midrst.fail_count", 64'(fail_count), 64'd0);
        checkOutput("midrst.first_fail", 64'(first_fail_addr), 64'd0);
        checkOutput("midrst.cycle_count", 64'(cycle_count), 64'd0);
        checkOutput("midrst.retired", 64'(retired_count), 64'd0);
        checkOutput("midrst.shadow3", 64'(dbg_data), 64'd0);
        dbg_addr = '0;
        clearProg();
        addWb(5'd31, 32'd1);
        executeRun("restart");
        checkOutput("restart.pass", 64'(pass), 64'd1);

        // Randomized runs against the model.
        for (int it = 0; it < 25; it++) begin
            bit no_marker;
            if ($urandom_range(0, 3) == 0) clrMask();
            for (int e = 0; e < int'($urandom_range(0, 4)); e++) begin
                progExp(5'($urandom_range(0, 31)), 32'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 7) == 0) begin
                exp_clr  = 1'b1;
                exp_we   = 1'b1;
                exp_addr = 5'($urandom_range(1, 31));
                exp_data = 32'($urandom_range(0, 3));
                tick();
                idleInputs();
                for (int i = 0; i < NREGS; i++) m_mask[i] = 1'b0;
            end
            clearProg();
            no_marker = ($urandom_range(0, 2) == 0);
            prog_len  = int'($urandom_range(1, 150));
            for (int k = 0; k < prog_len; k++) begin
                prog_en[k]    = ($urandom_range(0, 1) == 1);
                prog_addr[k]  = 5'($urandom_range(0, 31));
                prog_data[k]  = 32'($urandom_range(0, 3));
                if (no_marker && prog_addr[k] == 5'd31) prog_data[k] = '0;
                prog_start[k] = ($urandom_range(0, 15) == 0);
                prog_expwe[k] = ($urandom_range(0, 15) == 0);
            end
            executeRun($sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
